alu_mul_sequencer: RTL

- Multi-cycle unsigned 32x32->64 shift-add multiplier that computes with the single-cycle ALU. It does not contain its own adder.
- Sits between the CPU datapath and the ALU and owns the ALU input mux.
  - Idle: CPU operands and control pass straight through to the ALU.
  - Multiply in progress: the sequencer drives the ALU with ADD and stalls the CPU.

---
 rtl/alu_mul_sequencer_if.sv | 52 +++++
 rtl/alu_mul_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer_if
// Purpose  : Bundles the multiply handshake, the CPU-side ALU request/result
//            and the ALU-side operand/result signals of alu_mul_sequencer.
// Ports    : slave  - sequencer view (consumes requests, drives the ALU mux)
//            master - environment view (CPU issuing requests, ALU answering)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  // Multiply handshake
  logic               start_i;
  logic               flush_i;
  logic [WIDTH-1:0]   mul_a_i;
  logic [WIDTH-1:0]   mul_b_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] prod_o;
  // CPU side of the ALU mux
  logic [WIDTH-1:0]   cpu_src1_i;
  logic [WIDTH-1:0]   cpu_src2_i;
  logic [3:0]         cpu_ctrl_i;
  logic [WIDTH-1:0]   cpu_result_o;
  logic               cpu_stall_o;
  // ALU side of the ALU mux
  logic [WIDTH-1:0]   alu_src1_o;
  logic [WIDTH-1:0]   alu_src2_o;
  logic [3:0]         alu_ctrl_o;
  logic [WIDTH-1:0]   alu_result_i;
  logic               alu_cout_i;

  modport slave (
    input  start_i, flush_i, mul_a_i, mul_b_i,
    input  cpu_src1_i, cpu_src2_i, cpu_ctrl_i,
    input  alu_result_i, alu_cout_i,
    output busy_o, done_o, prod_o,
    output cpu_result_o, cpu_stall_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o
  );

  modport master (
    output start_i, flush_i, mul_a_i, mul_b_i,
    output cpu_src1_i, cpu_src2_i, cpu_ctrl_i,
    output alu_result_i, alu_cout_i,
    input  busy_o, done_o, prod_o,
    input  cpu_result_o, cpu_stall_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Purpose  : Unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that
//            borrows the CPU's single-cycle ALU for its additions. When idle
//            the CPU operands pass straight through to the ALU; while a
//            multiply runs the sequencer owns the ALU and stalls the CPU.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - asynchronous active-high reset
//            bus    - alu_mul_sequencer_if.slave (handshake, CPU and ALU mux)
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter int         CNT_W   = 6,
  parameter logic [3:0] ALU_ADD = 4'b0010
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  alu_mul_sequencer_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_accept;
  logic               w_last;
  logic [2*WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0]   w_alu_src1;
  logic [WIDTH-1:0]   w_alu_src2;
  logic [3:0]         w_alu_ctrl;

  assign w_accept = (r_state == S_IDLE) && bus.start_i && !bus.flush_i;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // {cout, sum, acc_lo} >> 1 keeping the low 2*WIDTH bits: the bit of acc_lo
  // just consumed as the multiplier bit falls off the bottom.
  assign w_shifted = {bus.alu_cout_i, bus.alu_result_i, r_acc_lo[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (bus.flush_i) w_state_next = S_IDLE;
               else if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ALU input mux. In DONE the ALU is still held (operands 0, ADD) so the
  // CPU sees no spurious op during its last stalled cycle.
  always_comb begin
    w_alu_src1 = bus.cpu_src1_i;
    w_alu_src2 = bus.cpu_src2_i;
    w_alu_ctrl = bus.cpu_ctrl_i;
    case (r_state)
      S_RUN: begin
        w_alu_src1 = r_acc_hi;
        // Adding zero on skip iterations keeps alu_cout_i low.
        w_alu_src2 = r_acc_lo[0] ? r_mcand : '0;
        w_alu_ctrl = ALU_ADD;
      end
      S_DONE: begin
        w_alu_src1 = '0;
        w_alu_src2 = '0;
        w_alu_ctrl = ALU_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mcand  <= bus.mul_a_i;
        r_acc_lo <= bus.mul_b_i;
        r_acc_hi <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_RUN && !bus.flush_i) begin
        r_acc_hi <= w_shifted[2*WIDTH-1:WIDTH];
        r_acc_lo <= w_shifted[WIDTH-1:0];
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) r_prod <= w_shifted;
      end
    end
  end

  assign bus.busy_o       = (r_state != S_IDLE);
  // A flush in DONE suppresses the pulse so an aborted op never reports done.
  assign bus.done_o       = (r_state == S_DONE) && !bus.flush_i;
  assign bus.prod_o       = r_prod;
  assign bus.cpu_stall_o  = (r_state != S_IDLE);
  assign bus.cpu_result_o = bus.alu_result_i;
  assign bus.alu_src1_o   = w_alu_src1;
  assign bus.alu_src2_o   = w_alu_src2;
  assign bus.alu_ctrl_o   = w_alu_ctrl;

endmodule
`default_nettype wire
